// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame/baud constants
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 10417;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Pointers carry one extra
// wrap bit so full and empty are distinguishable; head data is combinational.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_BITS,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter: valid/ready byte input, FIFO buffering, registered
// serial output with back-to-back frames when the FIFO stays non-empty.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    localparam int CW          = $clog2(CLKS_PER_BIT),
    localparam int FCW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      uart_rxd_out,
    output logic                      busy,
    output logic [FCW-1:0]            fifo_count
);

    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             baud_q, baud_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      line_q, line_d;
    logic                      pop;
    logic                      baud_end;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_valid),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end     = (baud_q == BAUD_LAST);
    assign tx_ready     = !fifo_full;
    assign busy         = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_rxd_out = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // The shift register is pre-shifted at each bit boundary, so shift_q[0]
    // always holds the next bit to put on the line.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    state_d = ST_START;
                    shift_d = fifo_rdata;
                end
            end
            ST_START: begin
                baud_d = baud_end ? '0 : baud_q + CW'(1);
                if (baud_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    shift_d = shift_q >> 1;
                end
            end
            ST_DATA: begin
                baud_d = baud_end ? '0 : baud_q + CW'(1);
                if (baud_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_end ? '0 : baud_q + CW'(1);
                if (baud_end) begin
                    if (!fifo_empty) begin
                        state_d = ST_START;
                        shift_d = fifo_rdata;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        line_d = line_q;
        case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    line_d = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end) line_d = shift_q[0];
            end
            ST_DATA: begin
                if (baud_end) line_d = (bit_q == BIT_LAST) ? 1'b1 : shift_q[0];
            end
            ST_STOP: begin
                if (baud_end) begin
                    pop    = !fifo_empty;
                    line_d = fifo_empty;
                end
            end
            default: line_d = 1'b1;
        endcase
    end

endmodule
